pool_feeder: RTL and testbench

POOL_FEEDER -- requirements
Module: pool_feeder

---
 rtl/pool_feeder.sv | 130 +++++++++++++
 tb/tb_pool_feeder.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pool_feeder.sv
// pool_feeder
// Collects a window of WIN samples from a valid/ready stream and presents
// the completed window to a downstream averaging pool. Once the window is
// full, input is stalled until the pool acknowledges it.
//
// Optional feature: define POOL_FEEDER_SUM_EN to build a running-sum
// accumulator. It drives sum_out and avg_out (average = sum / 64).
// Without the macro, no accumulator is built and both outputs are tied to 0.
//
// Ports
//   clk       in   sole clock, rising edge
//   rst       in   synchronous active-high reset
//   feed_en   in   allow new samples to be accepted
//   clear     in   discard the current window (contents kept, count zeroed)
//   s_valid   in   upstream sample valid
//   s_ready   out  block can accept a sample this cycle
//   s_data    in   upstream sample, DATA_W bits
//   pool_en   out  complete window presented downstream
//   pool_ack  in   downstream consumed the window
//   win_flat  out  window samples, sample k at [k*DATA_W +: DATA_W]
//   sum_out   out  22-bit running window sum (0 without POOL_FEEDER_SUM_EN)
//   avg_out   out  sum_out[21:6] (0 without POOL_FEEDER_SUM_EN)

module pool_feeder #(
  parameter int DATA_W = 16,
  parameter int WIN    = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  feed_en,
  input  logic                  clear,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_W-1:0]     s_data,
  output logic                  pool_en,
  input  logic                  pool_ack,
  output logic [WIN*DATA_W-1:0] win_flat,
  output logic [21:0]           sum_out,
  output logic [15:0]           avg_out
);

  localparam int IDX_W = $clog2(WIN);

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [6:0]        cnt;
  logic [DATA_W-1:0] slot_q [WIN];
  logic              handshake;
  logic              ack_take;
  logic              last_slot;

  // s_ready is forced low during reset so no sample can slip in on a reset edge.
  assign s_ready   = (state == FILL) && feed_en && !rst;
  assign handshake = s_valid && s_ready;
  assign ack_take  = (state == FULL) && pool_ack;
  assign last_slot = (cnt == 7'(WIN - 1));
  assign pool_en   = (state == FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_next;
    end
  end

  // clear wins over both the filling handshake and the acknowledge.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = FILL;
    end else begin
      case (state)
        FILL:    if (handshake && last_slot) state_next = FULL;
        FULL:    if (pool_ack) state_next = FILL;
        default: state_next = FILL;
      endcase
    end
  end

  // Slot counter: restarts at 0 after reset, clear or an accepted window.
  always_ff @(posedge clk) begin
    if (rst || clear || ack_take) begin
      cnt <= '0;
    end else if (handshake) begin
      cnt <= cnt + 7'd1;
    end
  end

  // Window storage. clear only rewinds the counter; stale slots keep their
  // values until overwritten by the next window.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < WIN; i++) begin
        slot_q[i] <= '0;
      end
    end else if (handshake && !clear) begin
      slot_q[cnt[IDX_W-1:0]] <= s_data;
    end
  end

  for (genvar g = 0; g < WIN; g++) begin : g_flat
    assign win_flat[g*DATA_W +: DATA_W] = slot_q[g];
  end

`ifdef POOL_FEEDER_SUM_EN
  logic [21:0] acc;

  // 64 samples of at most 16 bits fit exactly in 22 bits, so no wrap.
  always_ff @(posedge clk) begin
    if (rst || clear || ack_take) begin
      acc <= '0;
    end else if (handshake) begin
      acc <= acc + 22'(s_data);
    end
  end

  assign sum_out = acc;
  assign avg_out = acc[21:6];
`else
  assign sum_out = '0;
  assign avg_out = '0;
`endif

endmodule

// File: tb/tb_pool_feeder.sv
// tb_pool_feeder
// Self-checking bench for pool_feeder. A behavioural model tracks the
// accepted samples of the current window as a queue plus a persistent slot
// array; the expected outputs are derived from those. Honours
// POOL_FEEDER_SUM_EN for the sum/average expectations.

module tb_pool_feeder;

  logic          clk;
  logic          rst;
  logic          feed_en;
  logic          clear;
  logic          s_valid;
  logic          s_ready;
  logic [15:0]   s_data;
  logic          pool_en;
  logic          pool_ack;
  logic [1023:0] win_flat;
  logic [21:0]   sum_out;
  logic [15:0]   avg_out;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model state
  logic [15:0] m_win [64];
  logic [15:0] m_q [$];
  bit          m_full;

  pool_feeder #(.DATA_W(16), .WIN(64)) dut (
    .clk      (clk),
    .rst      (rst),
    .feed_en  (feed_en),
    .clear    (clear),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .pool_en  (pool_en),
    .pool_ack (pool_ack),
    .win_flat (win_flat),
    .sum_out  (sum_out),
    .avg_out  (avg_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1023:0] m_flat();
    logic [1023:0] f;
    for (int i = 0; i < 64; i++) f[i*16 +: 16] = m_win[i];
    return f;
  endfunction

  function automatic logic [21:0] m_sum();
    int s;
    s = 0;
`ifdef POOL_FEEDER_SUM_EN
    foreach (m_q[i]) s += int'(m_q[i]);
`endif
    return 22'(s);
  endfunction

  function automatic logic [15:0] m_avg();
    logic [21:0] s;
    s = m_sum();
    return s[21:6];
  endfunction

  function automatic logic m_ready();
    return !rst && !m_full && feed_en;
  endfunction

  // Advance one clock; model absorbs the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) m_win[i] = '0;
      m_q.delete();
      m_full = 1'b0;
    end else if (clear) begin
      m_q.delete();
      m_full = 1'b0;
    end else if (m_full) begin
      if (pool_ack) begin
        m_q.delete();
        m_full = 1'b0;
      end
    end else if (feed_en && s_valid) begin
      m_win[m_q.size()] = s_data;
      m_q.push_back(s_data);
      if (m_q.size() == 64) m_full = 1'b1;
    end
    #1;
  endtask

  task automatic idle_inputs();
    rst = 1'b0; feed_en = 1'b0; clear = 1'b0;
    s_valid = 1'b0; pool_ack = 1'b0; s_data = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    rst = 1'b1; feed_en = 1'b1; s_valid = 1'b1; clear = 1'b1; pool_ack = 1'b1;
    s_data = 16'($urandom);
    #1;
    n_checks++;
    if (s_ready !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_s_ready got %b expected 0", s_ready);
    end
    tick();
    tick();
    n_checks++;
    if (pool_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL reset_pool_en got %b expected 0", pool_en);
    end
    n_checks++;
    if (win_flat !== '0) begin
      n_fail++; $display("[TB] FAIL reset_win_flat got %h expected 0", win_flat);
    end
    n_checks++;
    if (sum_out !== 22'd0 || avg_out !== 16'd0) begin
      n_fail++; $display("[TB] FAIL reset_sum_avg got %h/%h expected 0/0", sum_out, avg_out);
    end
    idle_inputs();
  endtask

  task automatic test_back_to_back();
    logic [1023:0] exp_flat;
    $display("[TB] test_back_to_back");
    do_reset();
    feed_en = 1'b1; s_valid = 1'b1;
    for (int k = 0; k < 64; k++) begin
      s_data = 16'(k);
      exp_flat[k*16 +: 16] = 16'(k);
      tick();
      n_checks++;
      if (pool_en !== (k == 63)) begin
        n_fail++; $display("[TB] FAIL b2b_pool_en k=%0d got %b expected %b", k, pool_en, (k == 63));
      end
    end
    s_valid = 1'b0;
    n_checks++;
    if (win_flat !== exp_flat) begin
      n_fail++; $display("[TB] FAIL b2b_win_flat got %h expected %h", win_flat, exp_flat);
    end
    n_checks++;
`ifdef POOL_FEEDER_SUM_EN
    if (sum_out !== 22'd2016 || avg_out !== 16'd31) begin
      n_fail++; $display("[TB] FAIL b2b_sum got %0d/%0d expected 2016/31", sum_out, avg_out);
    end
`else
    if (sum_out !== 22'd0 || avg_out !== 16'd0) begin
      n_fail++; $display("[TB] FAIL b2b_sum got %0d/%0d expected 0/0", sum_out, avg_out);
    end
`endif
    pool_ack = 1'b1;
    tick();
    pool_ack = 1'b0;
    n_checks++;
    if (pool_en !== 1'b0) begin
      n_fail++; $display("[TB] FAIL b2b_ack got %b expected 0", pool_en);
    end
    idle_inputs();
  endtask

  task automatic test_saturate();
    $display("[TB] test_saturate");
    feed_en = 1'b1; s_valid = 1'b1; s_data = 16'hFFFF;
    for (int k = 0; k < 64; k++) tick();
    s_valid = 1'b0;
    n_checks++;
    if (win_flat !== {1024{1'b1}}) begin
      n_fail++; $display("[TB] FAIL sat_win_flat got %h expected all ones", win_flat);
    end
    n_checks++;
`ifdef POOL_FEEDER_SUM_EN
    if (sum_out !== 22'h3FFFC0 || avg_out !== 16'hFFFF) begin
      n_fail++; $display("[TB] FAIL sat_sum got %h/%h expected 3fffc0/ffff", sum_out, avg_out);
    end
`else
    if (sum_out !== 22'd0 || avg_out !== 16'd0) begin
      n_fail++; $display("[TB] FAIL sat_sum got %h/%h expected 0/0", sum_out, avg_out);
    end
`endif
    pool_ack = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_hold_ack();
    logic [15:0] d;
    int guard;
    $display("[TB] test_hold_ack");
    feed_en = 1'b1; s_valid = 1'b1; pool_ack = 1'b1;
    guard = 0;
    while (!m_full && guard < 200) begin
      s_data = 16'($urandom);
      s_valid = ($urandom_range(0, 3) != 0);
      tick();
      guard++;
      n_checks++;
      if (pool_en !== m_full) begin
        n_fail++; $display("[TB] FAIL hold_fill_pool_en got %b expected %b", pool_en, m_full);
      end
    end
    n_checks++;
    if (!m_full) begin
      n_fail++; $display("[TB] FAIL hold_fill_timeout got %0d cycles expected full window", guard);
    end
    pool_ack = 1'b0; s_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_data = 16'($urandom);
      #1;
      n_checks++;
      if (s_ready !== 1'b0) begin
        n_fail++; $display("[TB] FAIL hold_s_ready got %b expected 0", s_ready);
      end
      tick();
      n_checks++;
      if (pool_en !== 1'b1 || win_flat !== m_flat()) begin
        n_fail++; $display("[TB] FAIL hold_window got pool_en=%b %h expected 1 %h", pool_en, win_flat, m_flat());
      end
    end
    pool_ack = 1'b1;
    tick();
    pool_ack = 1'b0;
    n_checks++;
    if (pool_en !== 1'b0 || win_flat !== m_flat()) begin
      n_fail++; $display("[TB] FAIL hold_ack got pool_en=%b %h expected 0 %h", pool_en, win_flat, m_flat());
    end
    d = 16'($urandom);
    s_data = d;
    tick();
    n_checks++;
    if (win_flat[15:0] !== d) begin
      n_fail++; $display("[TB] FAIL hold_slot0 got %h expected %h", win_flat[15:0], d);
    end
    idle_inputs();
  endtask

  task automatic test_clear();
    logic [15:0] d;
    $display("[TB] test_clear");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    feed_en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      s_data = 16'($urandom);
      tick();
    end
    clear = 1'b1; s_data = 16'($urandom);
    tick();
    clear = 1'b0;
    n_checks++;
    if (win_flat !== m_flat()) begin
      n_fail++; $display("[TB] FAIL clear_drop got %h expected %h", win_flat, m_flat());
    end
    n_checks++;
    if (sum_out !== 22'd0) begin
      n_fail++; $display("[TB] FAIL clear_sum got %h expected 0", sum_out);
    end
    for (int i = 0; i < 64; i++) begin
      s_data = 16'($urandom);
      tick();
      n_checks++;
      if (pool_en !== (i == 63)) begin
        n_fail++; $display("[TB] FAIL clear_refill i=%0d got %b expected %b", i, pool_en, (i == 63));
      end
    end
    n_checks++;
    if (win_flat !== m_flat() || sum_out !== m_sum()) begin
      n_fail++; $display("[TB] FAIL clear_window got %h sum %h expected %h sum %h", win_flat, sum_out, m_flat(), m_sum());
    end
    clear = 1'b1; pool_ack = 1'b1;
    tick();
    clear = 1'b0; pool_ack = 1'b0;
    n_checks++;
    if (pool_en !== 1'b0 || win_flat !== m_flat()) begin
      n_fail++; $display("[TB] FAIL clear_full got pool_en=%b %h expected 0 %h", pool_en, win_flat, m_flat());
    end
    d = 16'($urandom);
    s_data = d;
    tick();
    n_checks++;
    if (win_flat[15:0] !== d) begin
      n_fail++; $display("[TB] FAIL clear_slot0 got %h expected %h", win_flat[15:0], d);
    end
    idle_inputs();
  endtask

  task automatic test_feed_toggle();
    logic [1023:0] exp_flat;
    int hs;
    int c;
    $display("[TB] test_feed_toggle");
    clear = 1'b1;
    tick();
    clear = 1'b0;
    exp_flat = m_flat();
    s_valid = 1'b1;
    hs = 0;
    c = 0;
    while (!pool_en && c < 1000) begin
      feed_en = ((c / 3) % 2 == 0);
      s_data = 16'($urandom);
      if (feed_en && hs < 64) begin
        exp_flat[hs*16 +: 16] = s_data;
        hs++;
      end
      tick();
      c++;
    end
    s_valid = 1'b0;
    n_checks++;
    if (hs !== 64 || !pool_en) begin
      n_fail++; $display("[TB] FAIL toggle_count got %0d handshakes pool_en=%b expected 64 1", hs, pool_en);
    end
    n_checks++;
    if (win_flat !== exp_flat) begin
      n_fail++; $display("[TB] FAIL toggle_order got %h expected %h", win_flat, exp_flat);
    end
    pool_ack = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    $display("[TB] test_reset_mid");
    feed_en = 1'b1; s_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      s_data = 16'($urandom);
      tick();
    end
    rst = 1'b1; s_data = 16'($urandom);
    tick();
    rst = 1'b0;
    n_checks++;
    if (pool_en !== 1'b0 || win_flat !== '0 || sum_out !== 22'd0 || avg_out !== 16'd0) begin
      n_fail++; $display("[TB] FAIL rstmid_outputs got %b %h %h %h expected all 0", pool_en, win_flat, sum_out, avg_out);
    end
    for (int i = 0; i < 64; i++) begin
      s_data = 16'($urandom);
      tick();
    end
    s_valid = 1'b0;
    n_checks++;
    if (pool_en !== 1'b1 || win_flat !== m_flat() || sum_out !== m_sum()) begin
      n_fail++; $display("[TB] FAIL rstmid_refill got %b %h sum %h expected 1 %h sum %h", pool_en, win_flat, sum_out, m_flat(), m_sum());
    end
    pool_ack = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic test_random();
    $display("[TB] test_random");
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 255) == 0);
      clear    = ($urandom_range(0, 63) == 0);
      pool_ack = ($urandom_range(0, 7) == 0);
      feed_en  = ($urandom_range(0, 3) != 0);
      s_valid  = ($urandom_range(0, 3) != 0);
      s_data   = 16'($urandom);
      #1;
      n_checks++;
      if (s_ready !== m_ready()) begin
        n_fail++; $display("[TB] FAIL rand_s_ready cycle %0d got %b expected %b", i, s_ready, m_ready());
      end
      tick();
      n_checks++;
      if (pool_en !== m_full) begin
        n_fail++; $display("[TB] FAIL rand_pool_en cycle %0d got %b expected %b", i, pool_en, m_full);
      end
      n_checks++;
      if (win_flat !== m_flat()) begin
        n_fail++; $display("[TB] FAIL rand_win_flat cycle %0d got %h expected %h", i, win_flat, m_flat());
      end
      n_checks++;
      if (sum_out !== m_sum() || avg_out !== m_avg()) begin
        n_fail++; $display("[TB] FAIL rand_sum cycle %0d got %h/%h expected %h/%h", i, sum_out, avg_out, m_sum(), m_avg());
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < 64; i++) m_win[i] = '0;
    m_full = 1'b0;
    idle_inputs();
    test_reset();
    test_back_to_back();
    test_saturate();
    test_hold_ack();
    test_clear();
    test_feed_toggle();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
